// File: rtl/dense_layer_stream.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_stream
// Brief    : Streaming fully-connected layer. One signed activation is taken
//            per cycle, and all OUT_SIZE neuron accumulators update in parallel.
//            Build macro DENSE_RELU_EN selects a ReLU on the output.
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_stream #(
  parameter int IN_SIZE  = 32,
  parameter int OUT_SIZE = 3,
  parameter int IN_W     = 32,
  parameter int W_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 40
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_W-1:0]                       in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_SIZE*ACC_W-1:0]             out_data,
  input  logic                                  cfg_we,
  input  logic                                  cfg_sel,
  input  logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]   cfg_addr,
  input  logic [W_W-1:0]                        cfg_data,
  output logic                                  busy
);

  localparam int c_ADDR_W = $clog2(IN_SIZE*OUT_SIZE);
  localparam int c_IDX_W  = $clog2(IN_SIZE);
  localparam int c_PROD_W = IN_W + W_W;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(IN_SIZE-1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_ACC  = 2'd1;
  localparam logic [1:0] c_S_OUT  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_in_ready;
  logic               w_hs;
  logic               w_cfg_ok;

  // Coefficient storage deliberately has no reset so it survives aborts.
  logic signed [W_W-1:0] r_wmem [IN_SIZE*OUT_SIZE];
  logic signed [B_W-1:0] r_bias [OUT_SIZE];

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == c_S_OUT);
  assign busy      = (r_state != c_S_IDLE);
  assign w_hs      = in_valid & r_in_ready;
  assign w_cfg_ok  = cfg_we && (r_state == c_S_IDLE) && (r_idx == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_hs) w_state_nxt = c_S_ACC;
      c_S_ACC:  if (w_hs && (r_idx == c_LAST)) w_state_nxt = c_S_OUT;
      c_S_OUT:  if (out_ready) w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // in_ready is registered from the next state, so it stays low until the
  // first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_S_IDLE;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != c_S_OUT);
      if ((r_state == c_S_OUT) && out_ready)
        r_idx <= '0;
      else if (w_hs)
        r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Registered write: a handshake in the same cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (w_cfg_ok && !cfg_sel && (int'(cfg_addr) < IN_SIZE*OUT_SIZE))
      r_wmem[cfg_addr] <= cfg_data;
  end

  generate
    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_neuron
      logic [c_ADDR_W-1:0]        w_raddr;
      logic signed [c_PROD_W-1:0] w_prod;
      logic signed [ACC_W-1:0]    w_prod_ext;
      logic signed [ACC_W-1:0]    w_bias_ext;
      logic signed [ACC_W-1:0]    w_act;
      logic signed [ACC_W-1:0]    r_acc;

      always_ff @(posedge clk) begin
        if (w_cfg_ok && cfg_sel && (int'(cfg_addr) == j))
          r_bias[j] <= cfg_data[B_W-1:0];
      end

      assign w_raddr    = c_ADDR_W'(int'(r_idx) * OUT_SIZE + j);
      assign w_prod     = $signed(in_data) * r_wmem[w_raddr];
      assign w_prod_ext = ACC_W'(w_prod);
      assign w_bias_ext = ACC_W'(r_bias[j]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_acc <= '0;
        else if (w_hs)
          r_acc <= (r_state == c_S_IDLE) ? (w_bias_ext + w_prod_ext)
                                         : (r_acc + w_prod_ext);
      end

`ifdef DENSE_RELU_EN
      assign w_act = r_acc[ACC_W-1] ? '0 : r_acc;
`else
      assign w_act = r_acc;
`endif

      assign out_data[j*ACC_W +: ACC_W] = w_act;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_layer_stream
// Brief    : Directed bench: a 4x2 instance for the frame/handshake cases and a
//            default-size 32x3 instance for the worst-case magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_layer_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [31:0] in_data = '0;
  logic [79:0] out_data;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;

  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_busy;
  logic [31:0]  b_in_data = '0;
  logic [137:0] b_out_data;
  logic         b_cfg_we = 1'b0, b_cfg_sel = 1'b0;
  logic [6:0]   b_cfg_addr = '0;
  logic [7:0]   b_cfg_data = '0;

  int n_vec = 0;
  int n_err = 0;

  dense_layer_stream #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(32), .W_W(8), .B_W(8), .ACC_W(40)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy));

  dense_layer_stream #(.IN_SIZE(32), .OUT_SIZE(3), .IN_W(32), .W_W(8), .B_W(8), .ACC_W(46)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
    .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .busy(b_busy));

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] act(input logic signed [63:0] v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [39:0] so(input int j);
    return out_data[j*40 +: 40];
  endfunction

  task automatic cfg_wr(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] x, input int gap);
    int cnt;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = x;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 40) check("hs_timeout", 0, 1);
    else @(posedge clk);
  endtask

  task automatic frame(input logic signed [31:0] x0, x1, x2, x3, input int gap, input string tag);
    send(x0, gap); send(x1, gap); send(x2, gap); send(x3, gap);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat_valid"}, 64'(out_valid), 1);
    check({tag, "_in_ready_low"}, 64'(in_ready), 0);
  endtask

  task automatic take(input logic signed [63:0] e0, e1, input string tag);
    check({tag, "_n0"}, so(0), act(e0));
    check({tag, "_n1"}, so(1), act(e1));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drained"}, 64'(out_valid), 0);
    check({tag, "_idle_ready"}, 64'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_acc", so(0), 0);
    rst = 1'b1;
    #1 check("rel_in_ready", 64'(in_ready), 0);

    for (int i = 0; i < 4; i++) begin
      cfg_wr(1'b0, 3'(2*i), 8'(i+1));
      cfg_wr(1'b0, 3'(2*i+1), 8'(-(i+1)));
    end
    cfg_wr(1'b1, 3'd0, 8'd5);
    cfg_wr(1'b1, 3'd1, -8'sd5);

    // back-to-back frame
    frame(1, 2, 3, 4, 0, "t1");
    take(35, -35, "t1");

    // gapped frame: bias must be counted once
    frame(1, 2, 3, 4, 3, "t2");
    take(35, -35, "t2");

    // output backpressure
    frame(-1, -1, -1, -1, 0, "t3");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_hold_n0", so(0), act(-5));
      check("t3_hold_ready", 64'(in_ready), 0);
    end
    check("t3_hold_valid", 64'(out_valid), 1);
    take(-5, 5, "t3");

    // write while busy is ignored
    send(1, 0); send(2, 0);
    check("t4_busy", 64'(busy), 1);
    cfg_wr(1'b0, 3'd0, 8'd100);
    send(3, 0); send(4, 0);
    @(negedge clk);
    in_valid = 1'b0;
    take(35, -35, "t4a");
    // write in IDLE takes effect next frame
    cfg_wr(1'b0, 3'd0, 8'd100);
    frame(1, 2, 3, 4, 0, "t4b");
    take(134, -35, "t4b");
    // same-cycle write and first beat: beat sees old weight 100
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd1;
    in_valid = 1'b1; in_data = 1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    send(2, 0); send(3, 0); send(4, 0);
    @(negedge clk);
    in_valid = 1'b0;
    take(134, -35, "t4c");
    // out-of-range bias write is dropped
    cfg_wr(1'b1, 3'd3, 8'd77);
    frame(1, 2, 3, 4, 0, "t4d");
    take(35, -35, "t4d");

    // reset mid-frame
    send(1, 0); send(2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 check("t5_async_busy", 64'(busy), 0);
    @(negedge clk);
    check("t5_rst_ready", 64'(in_ready), 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_valid", 64'(out_valid), 0);
    end
    frame(1, 2, 3, 4, 0, "t5");
    take(35, -35, "t5");

    // default-size worst case magnitude
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      b_cfg_we = 1'b1; b_cfg_sel = 1'b0; b_cfg_addr = 7'(i); b_cfg_data = 8'h80;
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      b_cfg_we = 1'b1; b_cfg_sel = 1'b1; b_cfg_addr = 7'(j); b_cfg_data = 8'd127;
    end
    @(negedge clk);
    b_cfg_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 32'h8000_0000;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    check("t6_valid", 64'(b_out_valid), 1);
    for (int j = 0; j < 3; j++) begin
      logic signed [45:0] v;
      v = b_out_data[j*46 +: 46];
      check("t6_out", v, act(64'sd8796093022335));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
